// File: rtl/npu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : npu_result_collector
// Brief    : Captures a frame of NUM_CLASSES signed NPU scores from D_OUT,
//            tracks the running signed argmax, raises irq when the frame is
//            complete and exposes status, result and scores on an Avalon-MM
//            read-only slave port.
// Revision : 1.0 - initial release
// ============================================================================
module npu_result_collector #(
    parameter int NUM_CLASSES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  d_out,
    input  logic        d_valid,
    input  logic        clear,
    input  logic        chipselect,
    input  logic        read,
    input  logic [2:0]  address,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic       c_COLLECT = 1'b0;
    localparam logic       c_DONE    = 1'b1;
    localparam logic [4:0] c_LAST    = 5'(NUM_CLASSES - 1);
    localparam logic [7:0] c_MIN_VAL = 8'h80;

    logic        r_state;
    logic [4:0]  r_wr_ptr;
    logic [7:0]  r_buf [NUM_CLASSES];
    logic [7:0]  r_max_val;
    logic [4:0]  r_max_idx;
    logic        r_overflow;
    logic [31:0] r_readdata;

    logic        w_busy;
    logic        w_done;
    logic [4:0]  w_base;
    logic [7:0]  w_pad [32];
    logic [31:0] w_rd_data;

    assign w_done   = (r_state == c_DONE);
    assign w_busy   = (r_state == c_COLLECT) && (r_wr_ptr != 5'd0);
    assign irq      = w_done;
    assign readdata = r_readdata;

    // Score view padded to the full 32-byte window; unused slots read as zero.
    genvar gi;
    for (gi = 0; gi < 32; gi++) begin : g_pad
        if (gi < NUM_CLASSES) begin : g_used
            assign w_pad[gi] = r_buf[gi];
        end else begin : g_zero
            assign w_pad[gi] = 8'h00;
        end
    end

    // Frame capture, argmax tracking and overflow detection; clear wins over d_valid.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= c_COLLECT;
            r_wr_ptr   <= 5'd0;
            r_max_val  <= c_MIN_VAL;
            r_max_idx  <= 5'd0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (d_valid) begin
            if (r_state == c_COLLECT) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (r_wr_ptr == 5'(i)) begin
                        r_buf[i] <= d_out;
                    end
                end
                // Strict compare keeps the lowest index on ties.
                if (($signed(d_out) > $signed(r_max_val)) || (r_wr_ptr == 5'd0)) begin
                    r_max_val <= d_out;
                    r_max_idx <= r_wr_ptr;
                end
                r_wr_ptr <= r_wr_ptr + 5'd1;
                if (r_wr_ptr == c_LAST) begin
                    r_state <= c_DONE;
                end
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Register-map read mux built from current (pre-update) register values.
    always_comb begin
        w_base    = {address - 3'd2, 2'b00};
        w_rd_data = 32'h0;
        case (address)
            3'd0:    w_rd_data = {19'h0, r_wr_ptr, 5'h0, r_overflow, w_done, w_busy};
            3'd1:    w_rd_data = {16'h0, r_max_val, 3'h0, r_max_idx};
            default: w_rd_data = {w_pad[w_base + 5'd3], w_pad[w_base + 5'd2],
                                  w_pad[w_base + 5'd1], w_pad[w_base]};
        endcase
    end

    // One-cycle read latency; readdata holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 32'h0;
        end else if (chipselect && read) begin
            r_readdata <= w_rd_data;
        end
    end

endmodule
`default_nettype wire
